// File: rtl/burst_pkg.sv
// Shared constants and state encoding for the burst feeder and its downstream FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package burst_pkg;

    localparam int DATA_W    = 6;
    localparam int BURST_LEN = 8;
    // Width of the word counter and buffer indices (covers 0..BURST_LEN).
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/burst_buffer.sv
// Burst register file: one write port, one zero-padding read port.
// Latency: write lands on the clock edge; read is combinational with write-through bypass.
// Backpressure: none, the owner decides when to write and read.
module burst_buffer
    import burst_pkg::*;
#(
    parameter int DATA_W    = burst_pkg::DATA_W,
    parameter int BURST_LEN = burst_pkg::BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [BURST_LEN-1:0] i_pad_mask,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [BURST_LEN];

    // Storage: reset clears every entry so no stale word can leak after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BURST_LEN; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                if (i_wr_idx == IDX_W'(i)) r_mem[i] <= i_wr_data;
            end
        end
    end

    // Read mux: masked-off or out-of-range indices read as zero; a same-edge write is forwarded.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            if (i_rd_idx == IDX_W'(i) && i_pad_mask[i]) begin
                o_rd_data = (i_wr_en && i_wr_idx == IDX_W'(i)) ? i_wr_data : r_mem[i];
            end
        end
    end

endmodule

// File: rtl/burst_feeder.sv
// Collects upstream words into fixed-length bursts (zero-padded on flush), then idles for a gap.
// Latency: burst words appear from the cycle after the fill-complete/flush edge, one per cycle.
// Backpressure: in_ready is low through SEND and GAP; held in_valid is taken on the next ready cycle.
module burst_feeder #(
    parameter int DATA_W     = burst_pkg::DATA_W,
    parameter int BURST_LEN  = burst_pkg::BURST_LEN,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        state,
    output logic [3:0]        word_cnt
);

    import burst_pkg::*;

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(BURST_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t               r_state;
    state_t               w_nxt_state;
    logic [IDX_W-1:0]     r_word_cnt;
    logic [IDX_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     r_rd_idx;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [GAP_W-1:0]     w_gap_nxt;
    logic [DATA_W-1:0]    r_out_data;
    logic                 r_out_valid;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_send_nxt;
    logic [BURST_LEN-1:0] w_pad_mask;
    logic [DATA_W-1:0]    w_rd_data;

    assign w_in_ready = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign w_accept   = in_valid && w_in_ready;
    assign w_send_nxt = (w_nxt_state == ST_SEND);

    // Entries at or beyond the count captured at SEND entry are padded with zero.
    always_comb begin
        w_pad_mask = '0;
        for (int i = 0; i < BURST_LEN; i++) w_pad_mask[i] = (IDX_W'(i) < w_cnt_nxt);
    end

    burst_buffer #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept),
        .i_wr_idx   (r_word_cnt),
        .i_wr_data  (in_data),
        .i_rd_idx   (r_rd_idx),
        .i_pad_mask (w_pad_mask),
        .o_rd_data  (w_rd_data)
    );

    // Next-state, word count and gap count; flush only matters while filling.
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_nxt   = r_word_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = IDX_W'(1);
                    w_nxt_state = (BURST_LEN == 1) ? ST_SEND : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) w_cnt_nxt = r_word_cnt + IDX_W'(1);
                if (flush || (w_accept && r_word_cnt == LAST_IDX)) w_nxt_state = ST_SEND;
            end
            ST_SEND: begin
                if (r_rd_idx == LEN_IDX) begin
                    w_nxt_state = ST_GAP;
                    w_gap_nxt   = '0;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_nxt_state = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // State, counters and output flops; the read index walks the buffer while SEND is next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_rd_idx    <= '0;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_word_cnt  <= w_cnt_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_rd_idx    <= w_send_nxt ? r_rd_idx + IDX_W'(1) : '0;
            r_out_valid <= w_send_nxt;
            r_out_data  <= w_send_nxt ? w_rd_data : '0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign state     = r_state;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_burst_feeder.sv
// Directed bench for burst_feeder: full bursts, flush padding, streaming, reset mid-burst.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: exercised by holding in_valid through SEND and GAP.
module tb_burst_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [5:0] out_data;
    logic       out_valid;
    logic [1:0] state;
    logic [3:0] word_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    burst_feeder #(
        .DATA_W     (6),
        .BURST_LEN  (8),
        .GAP_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .state     (state),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects to be called right after the transition edge into SEND.
    task automatic check_burst(input string tag, input logic [47:0] exp);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), 32'(out_valid), 32'd1);
            chk($sformatf("%s_dat%0d", tag, k), 32'(out_data), 32'(exp[k*6 +: 6]));
            chk($sformatf("%s_rdy%0d", tag, k), 32'(in_ready), 32'd0);
            tick();
        end
        chk({tag, "_end_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_end_dat"}, 32'(out_data), 32'd0);
        chk({tag, "_gap_state"}, 32'(state), 32'd3);
    endtask

    // Expects to be called in the first GAP cycle; leaves the block in IDLE.
    task automatic check_gap(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_gap_rdy%0d", tag, k), 32'(in_ready), 32'd0);
            chk($sformatf("%s_gap_vld%0d", tag, k), 32'(out_valid), 32'd0);
            tick();
        end
        chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_state"}, 32'(state), 32'd0);
        chk({tag, "_idle_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        int src;
        int exp_next;
        int run;
        int bursts;
        logic acc;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_dat", 32'(out_data), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);

        // Full burst 1..8 back to back.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 6'(i);
            tick();
            if (i == 3) chk("b1_cnt3", 32'(word_cnt), 32'd3);
            if (i == 3) chk("b1_state_fill", 32'(state), 32'd1);
        end
        in_valid = 1'b0;
        chk("b1_state_send", 32'(state), 32'd2);
        chk("b1_cnt8", 32'(word_cnt), 32'd8);
        check_burst("b1", {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1});
        check_gap("b1");

        // Flush in IDLE is ignored.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_state", 32'(state), 32'd0);
        chk("idle_flush_vld", 32'(out_valid), 32'd0);
        chk("idle_flush_cnt", 32'(word_cnt), 32'd0);
        tick();
        chk("idle_flush_vld2", 32'(out_valid), 32'd0);

        // Partial burst 5,6,7 then flush: zero padded.
        for (int i = 5; i <= 7; i++) begin
            in_valid = 1'b1; in_data = 6'(i);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("b2_cnt", 32'(word_cnt), 32'd3);
        check_burst("b2", {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd7, 6'd6, 6'd5});
        check_gap("b2");

        // Flush on the same edge as the 7th word 0x3F.
        for (int i = 1; i <= 7; i++) begin
            in_valid = 1'b1; in_data = (i == 7) ? 6'h3F : 6'(i + 32);
            flush = (i == 7);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
        chk("b3_cnt", 32'(word_cnt), 32'd7);
        check_burst("b3", {6'd0, 6'h3F, 6'd38, 6'd37, 6'd36, 6'd35, 6'd34, 6'd33});
        check_gap("b3");

        // Streaming: in_valid held high, source advances only on accept.
        src = 1; exp_next = 1; run = 0; bursts = 0;
        in_valid = 1'b1; in_data = 6'(src);
        for (int c = 0; c < 140; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) src++;
            if (src > 24) in_valid = 1'b0;
            in_data = 6'(src);
            if (state == 2'd2 || state == 2'd3)
                chk($sformatf("s_rdy_low%0d", c), 32'(in_ready), 32'd0);
            if (out_valid) begin
                chk($sformatf("s_dat%0d", exp_next), 32'(out_data), 32'(exp_next));
                exp_next++;
                run++;
            end else if (run != 0) begin
                chk($sformatf("s_run%0d", bursts), 32'(run), 32'd8);
                bursts++;
                run = 0;
            end
        end
        chk("s_words", 32'(exp_next), 32'd25);
        chk("s_bursts", 32'(bursts), 32'd3);
        chk("s_end_state", 32'(state), 32'd0);

        // Reset asserted during the 4th SEND cycle.
        for (int i = 10; i <= 17; i++) begin
            in_valid = 1'b1; in_data = 6'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("r_send1_dat", 32'(out_data), 32'd10);
        tick(); tick(); tick();
        chk("r_send4_dat", 32'(out_data), 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_vld", 32'(out_valid), 32'd0);
        chk("r_dat", 32'(out_data), 32'd0);
        chk("r_state", 32'(state), 32'd0);
        chk("r_cnt", 32'(word_cnt), 32'd0);
        chk("r_rdy", 32'(in_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("r_quiet%0d", k), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
